// File: rtl/uart_rx_if.sv
// Host-side bundle for the UART receiver: serial line in, byte + handshake out.
// master = line/host driver side, slave = receiver side.
interface uart_rx_if;
  logic       Sin;
  logic       ReceiveAck;
  logic       Receive;
  logic [7:0] Dout;
  logic       parityErr;

  modport master (output Sin, ReceiveAck, input Receive, Dout, parityErr);
  modport slave  (input Sin, ReceiveAck, output Receive, Dout, parityErr);
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits LSB first, odd parity, 1 stop bit.
// Oversamples the synchronized line and samples each bit at its centre.
module uart_rx #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);
  localparam int BIT_CNT  = CLK_FREQUENCY / BAUD_RATE;
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam int TW       = $clog2(BIT_CNT + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, ACK, WAITIDLE} state_t;

  state_t         state, nstate;
  logic [1:0]     sync_pipe;
  logic           sin_s;
  logic [TW-1:0]  timer, lim;
  logic [3:0]     bitcnt;
  logic [7:0]     shreg, dout_q;
  logic           par_bit, perr_q, recv_q;
  logic           run, tick;
  logic           shift_en, par_en, load, recv_clr;

  assign sin_s = sync_pipe[1];

  // Timer runs only while framing a byte; START waits half a bit to land mid start bit.
  assign run  = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
  assign lim  = (state == START) ? TW'(HALF_CNT - 1) : TW'(BIT_CNT - 1);
  assign tick = run && (timer == lim);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:     if (!sin_s) nstate = START;
      START:    if (tick) nstate = sin_s ? IDLE : DATA;
      DATA:     if (tick && bitcnt == 4'd7) nstate = PARITY;
      PARITY:   if (tick) nstate = STOP;
      STOP:     if (tick) nstate = ACK;
      ACK:      if (bus.ReceiveAck) nstate = WAITIDLE;
      WAITIDLE: if (!bus.ReceiveAck && sin_s) nstate = IDLE;
      default:  nstate = IDLE;
    endcase
  end

  always_comb begin
    shift_en = 1'b0;
    par_en   = 1'b0;
    load     = 1'b0;
    recv_clr = 1'b0;
    case (state)
      DATA:    shift_en = tick;
      PARITY:  par_en   = tick;
      STOP:    load     = tick;
      ACK:     recv_clr = bus.ReceiveAck;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_pipe <= 2'b11;
      timer     <= '0;
      bitcnt    <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      dout_q    <= '0;
      perr_q    <= 1'b0;
      recv_q    <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[0], bus.Sin};
      if (!run || tick) timer <= '0;
      else              timer <= timer + 1'b1;
      if (state == IDLE)  bitcnt <= '0;
      else if (shift_en)  bitcnt <= bitcnt + 4'd1;
      if (shift_en) shreg   <= {sin_s, shreg[7:1]};
      if (par_en)   par_bit <= sin_s;
      // Stop bit value is not checked: a framing error still delivers the byte.
      if (load) begin
        dout_q <= shreg;
        perr_q <= ~(^{shreg, par_bit});
      end
      if (load)          recv_q <= 1'b1;
      else if (recv_clr) recv_q <= 1'b0;
    end
  end

  assign bus.Receive   = recv_q;
  assign bus.Dout      = dout_q;
  assign bus.parityErr = perr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of directed frames, corner sequences, and random frames
// checked against a parity model computed from the frame contents.
module tb_uart_rx;
  localparam int CLKF  = 1_600_000;
  localparam int BAUD  = 100_000;
  localparam int BITC  = CLKF / BAUD;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  uart_rx_if bus();
  uart_rx #(.CLK_FREQUENCY(CLKF), .BAUD_RATE(BAUD)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       par_ok;
    logic [7:0] exp_dout;
    logic       exp_perr;
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame; if rst_at matches a bit slot, assert reset halfway into it and stop.
  task automatic send(input logic [7:0] d, input logic p, input logic stp, input int rst_at);
    logic [10:0] fr;
    fr = {stp, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      bus.Sin = fr[i];
      if (i == rst_at) begin
        cyc(BITC / 2);
        rst = 1'b0;
        return;
      end
      cyc(BITC);
    end
  endtask

  function automatic logic model_perr(input logic [7:0] d, input logic p);
    return ((($countones(d) + int'(p)) % 2) == 0);
  endfunction

  task automatic expect_byte(input string name, input logic [7:0] d, input logic perr,
                             input int ack_delay);
    check({name, " receive"}, bus.Receive, 1);
    check({name, " dout"}, bus.Dout, d);
    check({name, " perr"}, bus.parityErr, perr);
    cyc(ack_delay);
    check({name, " receive held"}, bus.Receive, 1);
    bus.ReceiveAck = 1'b1;
    cyc(2);
    check({name, " receive cleared"}, bus.Receive, 0);
    cyc(3);
    check({name, " receive low w/ ack"}, bus.Receive, 0);
    bus.ReceiveAck = 1'b0;
    cyc(100);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b, d, hold_d;
    logic       p;
    int         errs;

    tbl[0] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
    tbl[1] = '{8'h00, 1'b1, 8'h00, 1'b0};
    tbl[2] = '{8'h0F, 1'b1, 8'h0F, 1'b0};
    tbl[3] = '{8'hF0, 1'b1, 8'hF0, 1'b0};
    tbl[4] = '{8'h37, 1'b1, 8'h37, 1'b0};
    tbl[5] = '{8'h73, 1'b1, 8'h73, 1'b0};
    tbl[6] = '{8'hAA, 1'b1, 8'hAA, 1'b0};
    tbl[7] = '{8'h55, 1'b1, 8'h55, 1'b0};
    tbl[8] = '{8'h37, 1'b0, 8'h37, 1'b1};

    bus.Sin = 1'b1;
    bus.ReceiveAck = 1'b0;
    cyc(5);
    rst = 1'b1;
    cyc(5);
    check("reset receive", bus.Receive, 0);
    check("reset dout", bus.Dout, 0);
    check("reset perr", bus.parityErr, 0);

    foreach (tbl[i]) begin
      b = tbl[i].data;
      p = tbl[i].par_ok ? ~^b : ^b;
      send(b, p, 1'b1, -1);
      expect_byte($sformatf("tbl%0d", i), tbl[i].exp_dout, tbl[i].exp_perr, 0);
    end

    // Short low pulse on an idle line must be rejected as a glitch.
    bus.Sin = 1'b0;
    cyc(4);
    bus.Sin = 1'b1;
    cyc(3 * BITC);
    check("glitch no receive", bus.Receive, 0);
    send(8'hA5, ~^8'hA5, 1'b1, -1);
    expect_byte("after glitch", 8'hA5, 1'b0, 0);

    // Host slow to ack: output must stay put.
    send(8'h3C, ~^8'h3C, 1'b1, -1);
    errs = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.Receive !== 1'b1 || bus.Dout !== 8'h3C) errs++;
      cyc(1);
    end
    check("hold stable cycles bad", errs, 0);
    expect_byte("hold", 8'h3C, 1'b0, 0);

    // Framing error: stop bit low, line left low afterwards.
    send(8'h96, ~^8'h96, 1'b0, -1);
    expect_byte("framing", 8'h96, 1'b0, 0);
    check("line low no restart", bus.Receive, 0);
    bus.Sin = 1'b1;
    cyc(20);
    send(8'hC3, ~^8'hC3, 1'b1, -1);
    expect_byte("after framing", 8'hC3, 1'b0, 0);

    // Reset in the middle of data bit 4 (slot 5 of the frame).
    send(8'h5A, ~^8'h5A, 1'b1, 5);
    #1;
    check("midreset receive", bus.Receive, 0);
    check("midreset dout", bus.Dout, 0);
    check("midreset perr", bus.parityErr, 0);
    cyc(3);
    bus.Sin = 1'b1;
    rst = 1'b1;
    cyc(20);
    send(8'h55, ~^8'h55, 1'b1, -1);
    expect_byte("after reset", 8'h55, 1'b0, 0);

    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom_range(0, 255));
      p = 1'($urandom_range(0, 1));
      hold_d = d;
      send(d, p, 1'b1, -1);
      expect_byte($sformatf("rnd%0d", i), hold_d, model_perr(d, p), $urandom_range(0, 30));
      cyc($urandom_range(0, 40));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
